// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back queue.
package regfile_pkg;
  localparam int REG_IDX_W = 5;
  localparam int ZERO_REG  = 31;
  localparam int DATA_W    = 64;

  // Field is named idx because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wq_lookup.sv
// Youngest-match forwarding search over the live entries of the write queue.
module regfile_wq_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic [DEPTH-1:0][REG_IDX_W-1:0] regs,
  input  logic [DEPTH-1:0][DATA_W-1:0]    datas,
  input  logic [PTR_W-1:0]                head,
  input  logic [CNT_W-1:0]                count,
  input  logic [REG_IDX_W-1:0]            lookup_reg,
  output logic                            hit,
  output logic [DATA_W-1:0]               data
);
  localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_REG);

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (regs[idx] == lookup_reg) && (lookup_reg != ZR)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// Circular write-back queue feeding the register file write port, with
// forwarding lookup of still-pending writes.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [4:0]           wr_reg,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  input  logic                 drain_en,
  output logic                 RegWrite,
  output logic [4:0]           WriteRegister,
  output logic [DATA_W-1:0]    WriteData,
  input  logic [4:0]           lookup_reg,
  output logic                 lookup_hit,
  output logic [DATA_W-1:0]    lookup_data,
  output logic [CNT_W-1:0]     count
);
  localparam logic [REG_IDX_W-1:0] ZR   = REG_IDX_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]     FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0][REG_IDX_W-1:0] regs;
  logic [DEPTH-1:0][DATA_W-1:0]    datas;
  logic [PTR_W-1:0]                head, tail;
  logic                            not_empty, push, pop;

  assign not_empty = (count != '0);
  assign wr_ready  = (count != FULL);
  // Zero-register writes are accepted but never stored.
  assign push      = wr_valid & wr_ready & (wr_reg != ZR);
  assign pop       = RegWrite;

  assign RegWrite      = drain_en & not_empty;
  assign WriteRegister = not_empty ? regs[head]  : '0;
  assign WriteData     = not_empty ? datas[head] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; liveness is tracked by head/count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      regs[tail]  <= wr_reg;
      datas[tail] <= wr_data;
    end
  end

  regfile_wq_lookup #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) u_lookup (
    .regs       (regs),
    .datas      (datas),
    .head       (head),
    .count      (count),
    .lookup_reg (lookup_reg),
    .hit        (lookup_hit),
    .data       (lookup_data)
  );
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed table-driven bench for regfile_write_queue (DEPTH=4, DATA_W=64).
module tb_regfile_write_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        drain_en;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  lookup_reg;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_queue #(.DEPTH(4), .DATA_W(64), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .drain_en      (drain_en),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .lookup_reg    (lookup_reg),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
    .count         (count)
  );

  typedef struct {
    logic        chk;
    logic        rst;
    logic        vld;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic        drain;
    logic [4:0]  lreg;
    logic        rw;
    logic [4:0]  ewreg;
    logic [63:0] ewdata;
    logic        rdy;
    logic        hit;
    logic [63:0] ldata;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic chk, logic rst, logic vld, logic [4:0] wreg,
                              logic [63:0] wdata, logic drain, logic [4:0] lreg,
                              logic rw, logic [4:0] ewreg, logic [63:0] ewdata,
                              logic rdy, logic hit, logic [63:0] ldata, logic [2:0] cnt);
    vec_t v;
    v.chk = chk; v.rst = rst; v.vld = vld; v.wreg = wreg; v.wdata = wdata;
    v.drain = drain; v.lreg = lreg; v.rw = rw; v.ewreg = ewreg; v.ewdata = ewdata;
    v.rdy = rdy; v.hit = hit; v.ldata = ldata; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [4:0] seen[$];
    int cyc;

    reset = 1'b1; wr_valid = 1'b0; wr_reg = '0; wr_data = '0;
    drain_en = 1'b0; lookup_reg = '0;

    //             chk rst vld wreg  wdata      drn lreg  rw wreg  wdata      rdy hit ldata     cnt
    vecs.push_back(mk(0, 1, 0, 5'd0,  64'h0,      0, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    // reset state, then single push / drain
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 1, 5'd5,  64'hAA,     1, 5'd5,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd5,  1, 5'd5,  64'hAA,     1, 1, 64'hAA,    3'd1));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd5,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    // fill while held off, refused fifth push, then drain in order
    vecs.push_back(mk(1, 0, 1, 5'd1,  64'h101,    0, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 1, 5'd2,  64'h102,    0, 5'd0,  0, 5'd1,  64'h101,    1, 0, 64'h0,     3'd1));
    vecs.push_back(mk(1, 0, 1, 5'd3,  64'h103,    0, 5'd0,  0, 5'd1,  64'h101,    1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd4,  64'h104,    0, 5'd0,  0, 5'd1,  64'h101,    1, 0, 64'h0,     3'd3));
    vecs.push_back(mk(1, 0, 1, 5'd9,  64'h109,    0, 5'd3,  0, 5'd1,  64'h101,    0, 1, 64'h103,   3'd4));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      0, 5'd9,  0, 5'd1,  64'h101,    0, 0, 64'h0,     3'd4));
    vecs.push_back(mk(1, 0, 1, 5'd10, 64'h10A,    1, 5'd0,  1, 5'd1,  64'h101,    0, 0, 64'h0,     3'd4));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd10, 1, 5'd2,  64'h102,    1, 0, 64'h0,     3'd3));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd0,  1, 5'd3,  64'h103,    1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd0,  1, 5'd4,  64'h104,    1, 0, 64'h0,     3'd1));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    // youngest-match lookup
    vecs.push_back(mk(1, 0, 1, 5'd7,  64'h11,     0, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 1, 5'd7,  64'h22,     0, 5'd7,  0, 5'd7,  64'h11,     1, 1, 64'h11,    3'd1));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      0, 5'd7,  0, 5'd7,  64'h11,     1, 1, 64'h22,    3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      0, 5'd8,  0, 5'd7,  64'h11,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      0, 5'd31, 0, 5'd7,  64'h11,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd7,  1, 5'd7,  64'h11,     1, 1, 64'h22,    3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd7,  1, 5'd7,  64'h22,     1, 1, 64'h22,    3'd1));
    // zero-register write is dropped
    vecs.push_back(mk(1, 0, 1, 5'd31, 64'hFF,     1, 5'd31, 0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd31, 0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    // steady state at count=2 with push+pop every cycle; pointers wrap
    vecs.push_back(mk(1, 0, 1, 5'd11, 64'hB1,     0, 5'd0,  0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 1, 5'd12, 64'hB2,     0, 5'd0,  0, 5'd11, 64'hB1,     1, 0, 64'h0,     3'd1));
    vecs.push_back(mk(1, 0, 1, 5'd13, 64'hB3,     1, 5'd0,  1, 5'd11, 64'hB1,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd14, 64'hB4,     1, 5'd0,  1, 5'd12, 64'hB2,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd15, 64'hB5,     1, 5'd0,  1, 5'd13, 64'hB3,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd16, 64'hB6,     1, 5'd0,  1, 5'd14, 64'hB4,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd17, 64'hB7,     1, 5'd0,  1, 5'd15, 64'hB5,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 1, 5'd18, 64'hB8,     1, 5'd17, 1, 5'd16, 64'hB6,     1, 1, 64'hB7,    3'd2));
    // reset mid-stream overrides the concurrent push and pop
    vecs.push_back(mk(1, 1, 1, 5'd19, 64'hB9,     1, 5'd0,  1, 5'd17, 64'hB7,     1, 0, 64'h0,     3'd2));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd18, 0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  64'h0,      1, 5'd19, 0, 5'd0,  64'h0,      1, 0, 64'h0,     3'd0));

    foreach (vecs[r]) begin
      reset = vecs[r].rst; wr_valid = vecs[r].vld; wr_reg = vecs[r].wreg;
      wr_data = vecs[r].wdata; drain_en = vecs[r].drain; lookup_reg = vecs[r].lreg;
      @(negedge clk);
      if (vecs[r].chk) begin
        check("RegWrite",      r, 64'(RegWrite),      64'(vecs[r].rw));
        check("WriteRegister", r, 64'(WriteRegister), 64'(vecs[r].ewreg));
        check("WriteData",     r, WriteData,          vecs[r].ewdata);
        check("wr_ready",      r, 64'(wr_ready),      64'(vecs[r].rdy));
        check("lookup_hit",    r, 64'(lookup_hit),    64'(vecs[r].hit));
        check("lookup_data",   r, lookup_data,        vecs[r].ldata);
        check("count",         r, 64'(count),         64'(vecs[r].cnt));
      end
      @(posedge clk); #1;
    end

    // Held-off fill of three entries, then drain and collect the write order.
    reset = 1'b0; drain_en = 1'b0; lookup_reg = '0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_reg = 5'(20 + k); wr_data = 64'(32'hC0 + k);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; drain_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      if (RegWrite) seen.push_back(WriteRegister);
      @(posedge clk); #1;
      cyc++;
    end while (RegWrite && cyc < 8);
    check("drain_cycles", 100, 64'(seen.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      check("drain_order", 100 + k, (k < seen.size()) ? 64'(seen[k]) : 64'hDEAD, 64'(20 + k));
    @(negedge clk);
    check("final_count", 104, 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Buffers register-file write-back requests and presents them one per cycle on the register file's write interface (RegWrite, WriteRegister, WriteData). That interface feeds the 5:32 write-enable decoder and the register array.
- Sits between the write-back source and the register file, so a producer can post writes while the register file is held off (drain_en low).
- Provides a youngest-match forwarding lookup, so readers see values that are still pending.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- DATA_W, 64, register data width.
- ZERO_REG, 31, register index whose writes are discarded (hardwired zero register).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer has a write request.
- wr_reg  input  5  destination register of the request.
- wr_data  input  DATA_W  data of the request.
- wr_ready  output  1  queue can accept a request this cycle.
- drain_en  input  1  register file may accept a write this cycle.
- RegWrite  output  1  write strobe to the register file and decoder.
- WriteRegister  output  5  register index of the head entry.
- WriteData  output  DATA_W  data of the head entry.
- lookup_reg  input  5  register index to search for pending writes.
- lookup_hit  output  1  a pending entry targets lookup_reg.
- lookup_data  output  DATA_W  data of the youngest matching entry.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage is a circular buffer of DEPTH entries {reg[4:0], data}, with head pointer, tail pointer and occupancy count. Pointers are log2(DEPTH) bits and wrap naturally.
- Reset (synchronous, reset=1 at a rising edge):
  - head, tail and count go to 0.
  - Outputs: RegWrite=0, WriteRegister=0, WriteData=0, wr_ready=1, lookup_hit=0, lookup_data=0, count=0.
  - Entry contents need not be cleared.
  - Reset overrides any push or pop in the same cycle; in-flight entries are lost.
- wr_ready = (count != DEPTH). It is combinational from state only and does not depend on pop in the same cycle.
- Push: when wr_valid & wr_ready at the edge.
  - If wr_reg == ZERO_REG: the request is accepted and dropped; no entry is stored and count is unchanged.
  - Otherwise: the entry is written at tail, tail increments, count increments.
- Pop:
  - RegWrite = drain_en & (count != 0), combinational.
  - WriteRegister and WriteData show the head entry whenever count != 0, and are 0 when empty.
  - At an edge with RegWrite=1: head increments and count decrements.
  - Latency: a request pushed at edge N is visible on the write interface in the cycle after edge N, provided the queue was empty. It writes the register file at edge N+1 if drain_en is high in that cycle.
  - There is no bypass from wr_* to the write interface in the same cycle.
- Simultaneous push and pop: both take effect and count is unchanged. When full, push is refused even if a pop occurs the same cycle.
- Write order to the register file equals acceptance order.
- Lookup (combinational):
  - Scan all valid entries, oldest to youngest; the youngest entry with reg == lookup_reg wins, giving lookup_hit=1 and lookup_data = its data.
  - No match, empty queue, or lookup_reg == ZERO_REG gives lookup_hit=0 and lookup_data=0.
  - The head entry is still valid for lookup in the cycle it is being popped.
- count never exceeds DEPTH and never underflows; attempted pops when empty have no effect.

Decomposition:
- Shared package regfile_pkg:
  - REG_IDX_W=5, ZERO_REG=31, DATA_W=64.
  - typedef wb_entry_t {logic [4:0] reg; logic [63:0] data}.
- One sub-module: regfile_wq_lookup, a combinational youngest-match search over the entry array given head and count.
- The queue control logic stays in the top module.

Test Plan:
- Reset, then idle with drain_en=1: RegWrite=0, WriteRegister=0, WriteData=0, count=0, wr_ready=1.
- Push reg 5 with data 0xAA with drain_en=1: the next cycle shows RegWrite=1, WriteRegister=5, WriteData=0xAA; the following cycle RegWrite=0 and count=0.
- drain_en=0 with pushes to regs 1, 2, 3, 4:
  - count=4 and wr_ready=0; a fifth push is not accepted.
  - Then drain_en=1: RegWrite is 1 for 4 cycles with WriteRegister 1, 2, 3, 4 in order, and wr_ready=1 after the first pop.
- drain_en=0, push reg 7 with data 0x11, then reg 7 with data 0x22:
  - lookup_reg=7 gives lookup_hit=1, lookup_data=0x22.
  - lookup_reg=8 gives lookup_hit=0.
  - lookup_reg=31 gives lookup_hit=0.
- Push reg 31 with data 0xFF: wr_ready=1 at push and count stays 0; RegWrite never asserts.
- With count=2 and drain_en=1:
  - Push each cycle for 6 cycles: count stays 2, and the pointers wrap past DEPTH with correct order.
  - Assert reset mid-stream: the next cycle count=0 and RegWrite=0.
